// File: rtl/checksum_gen.sv
// checksum_gen: passes a FRAME_LEN-bit serial payload through with one cycle
// of latency, then appends its CS_WIDTH-bit CRC MSB-first on the same stream.
//
// Ports:
//   tck_i    clock, rising edge
//   rst_ni   asynchronous active-low reset
//   start_i  frame start pulse, honoured only in IDLE
//   data_i   serial payload bit
//   valid_i  data_i is valid
//   ready_o  data_i is accepted this cycle (PAYLOAD only)
//   data_o   registered serial output bit
//   valid_o  registered data_o qualifier
//   done_o   high with the last checksum bit on data_o
//   busy_o   high outside IDLE
//   crc_o    checksum of the last completed payload
module checksum_gen #(
    parameter int unsigned          FRAME_LEN = 72,
    parameter int unsigned          CS_WIDTH  = 16,
    parameter logic [CS_WIDTH-1:0]  POLY      = 16'h1021,
    parameter logic [CS_WIDTH-1:0]  INIT      = 16'hFFFF
) (
    input  logic                tck_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                data_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic                data_o,
    output logic                valid_o,
    output logic                done_o,
    output logic                busy_o,
    output logic [CS_WIDTH-1:0] crc_o
);

    localparam int unsigned MAXW = (FRAME_LEN > CS_WIDTH) ? FRAME_LEN : CS_WIDTH;
    localparam int unsigned CW   = $clog2(MAXW) + 1;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t LAST_PL = cnt_t'(FRAME_LEN - 1);
    localparam cnt_t LAST_CS = cnt_t'(CS_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        APPEND,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CS_WIDTH-1:0] crc_q, crc_d;
    logic [CS_WIDTH-1:0] crc_out_q, crc_out_d;
    logic [CS_WIDTH-1:0] crc_nx;
    cnt_t                cnt_q, cnt_d;
    logic                data_q, data_d;
    logic                valid_q, valid_d;
    logic                fb;

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        crc_out_d = crc_out_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        fb        = 1'b0;
        crc_nx    = crc_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = PAYLOAD;
                    crc_d   = INIT;
                    cnt_d   = '0;
                end
            end
            PAYLOAD: begin
                if (valid_i) begin
                    fb      = crc_q[CS_WIDTH-1] ^ data_i;
                    crc_nx  = (crc_q << 1) ^ (fb ? POLY : '0);
                    crc_d   = crc_nx;
                    data_d  = data_i;
                    valid_d = 1'b1;
                    if (cnt_q == LAST_PL) begin
                        state_d   = APPEND;
                        crc_out_d = crc_nx;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            APPEND: begin
                // Shift the finished CRC out MSB-first, one bit per cycle.
                data_d  = crc_q[CS_WIDTH-1];
                valid_d = 1'b1;
                crc_d   = crc_q << 1;
                if (cnt_q == LAST_CS) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge tck_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            crc_q     <= INIT;
            crc_out_q <= '0;
            cnt_q     <= '0;
            data_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            crc_out_q <= crc_out_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    // The last checksum bit is held on data_o during DONE.
    assign ready_o = (state_q == PAYLOAD);
    assign busy_o  = (state_q != IDLE);
    assign done_o  = (state_q == DONE);
    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign crc_o   = crc_out_q;

endmodule

// File: tb/tb_checksum_gen.sv
// tb_checksum_gen: directed scoreboard bench for checksum_gen using the
// "123456789" reference frame and its CRC-16/CCITT-FALSE value 0x29B1.
module tb_checksum_gen;

    localparam logic [15:0] REF_CS = 16'h29B1;

    typedef struct packed {
        logic d;
        logic last;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        data_i;
    logic        valid_i;
    logic        ready_o;
    logic        data_o;
    logic        valid_o;
    logic        done_o;
    logic        busy_o;
    logic [15:0] crc_o;

    exp_t sb[$];
    logic pl[72];
    int   n_cmp;
    int   n_err;

    checksum_gen dut (
        .tck_i   (clk),
        .rst_ni  (rst_n),
        .start_i (start_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .done_o  (done_o),
        .busy_o  (busy_o),
        .crc_o   (crc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every valid output bit must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_o) begin
                if (sb.size() == 0) begin
                    chk("extra_out", 32'(valid_o), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("data_o", 32'(data_o), 32'(e.d));
                    chk("done_o", 32'(done_o), 32'(e.last));
                end
            end else begin
                chk("done_nv", 32'(done_o), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit throttle, input bit spurious,
                              input bit hold, input bit sv_start,
                              input int nbits);
        start_i = 1'b1;
        valid_i = sv_start;
        data_i  = 1'b1;
        chk("idle_ready", 32'(ready_o), 32'd0);
        tick();
        start_i = 1'b0;
        valid_i = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (throttle && i > 0) begin
                valid_i = 1'b0;
                tick();
                tick();
            end
            chk("pl_ready", 32'(ready_o), 32'd1);
            valid_i = 1'b1;
            data_i  = pl[i];
            start_i = spurious && (i == 40);
            sb.push_back('{d: pl[i], last: 1'b0});
            tick();
            start_i = 1'b0;
        end
        valid_i = 1'b0;
        if (nbits < 72) return;
        for (int j = 0; j < 16; j++) begin
            sb.push_back('{d: REF_CS[15-j], last: (j == 15)});
        end
        for (int c = 0; c < 17; c++) begin
            valid_i = hold;
            data_i  = 1'($urandom);
            start_i = spurious && (c == 5);
            chk("app_ready", 32'(ready_o), 32'd0);
            chk("app_busy", 32'(busy_o), 32'd1);
            tick();
            start_i = 1'b0;
        end
        valid_i = 1'b0;
        chk("end_busy", 32'(busy_o), 32'd0);
        chk("crc_o", 32'(crc_o), 32'(REF_CS));
        chk("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        n_cmp   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        start_i = 1'b0;
        data_i  = 1'b0;
        valid_i = 1'b0;
        for (int k = 0; k < 9; k++) begin
            b = 8'h31 + 8'(k);
            for (int j = 0; j < 8; j++) pl[k*8+j] = b[7-j];
        end

        #2;
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_ready", 32'(ready_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_crc", 32'(crc_o), 32'd0);
        #10;
        rst_n = 1'b1;
        tick();

        // Reference frame; start is paired with a valid bit that must be dropped.
        send_frame(1'b0, 1'b0, 1'b0, 1'b1, 72);
        // Throttled input.
        send_frame(1'b1, 1'b0, 1'b0, 1'b0, 72);
        // Valid held through APPEND/DONE.
        send_frame(1'b0, 1'b0, 1'b1, 1'b0, 72);
        // Spurious starts in PAYLOAD and APPEND.
        send_frame(1'b0, 1'b1, 1'b0, 1'b0, 72);

        // Reset in the middle of a frame.
        send_frame(1'b0, 1'b0, 1'b0, 1'b0, 20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_data", 32'(data_o), 32'd0);
        chk("mid_valid", 32'(valid_o), 32'd0);
        chk("mid_done", 32'(done_o), 32'd0);
        chk("mid_ready", 32'(ready_o), 32'd0);
        chk("mid_busy", 32'(busy_o), 32'd0);
        chk("mid_crc", 32'(crc_o), 32'd0);
        sb.delete();
        tick();
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        send_frame(1'b0, 1'b0, 1'b0, 1'b0, 72);

        // Back-to-back frames.
        send_frame(1'b0, 1'b0, 1'b0, 1'b0, 72);
        send_frame(1'b0, 1'b0, 1'b0, 1'b0, 72);

        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/checksum_gen.md
Name: checksum_gen

Overview:
- Transmit-side companion to the bitstream checksum checker on the JTAG path.
- Takes a serial payload of FRAME_LEN bits, passes it through registered, computes a serial CRC, then appends the CS_WIDTH-bit checksum MSB-first.
- The checker at the far end sees payload followed by checksum.
- Sits between the JTAG-side bitstream source and the serial configuration chain, clocked on tck_i.

Parameters:
- FRAME_LEN, 72: payload bits per frame, must be 1 or more.
- CS_WIDTH, 16: checksum width in bits.
- POLY, 16'h1021: CRC generator polynomial with the implicit top bit omitted; width CS_WIDTH.
- INIT, 16'hFFFF: CRC register value loaded at frame start; width CS_WIDTH.

Ports:
- tck_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle pulse that begins a frame; only honoured in IDLE.
- data_i  in  1  serial payload bit.
- valid_i  in  1  data_i is valid.
- ready_o  out  1  block accepts data_i this cycle.
- data_o  out  1  serial output bit, registered.
- valid_o  out  1  data_o is valid, registered.
- done_o  out  1  single-cycle pulse coinciding with the last checksum bit on data_o.
- busy_o  out  1  high in every state except IDLE.
- crc_o  out  CS_WIDTH  final checksum of the last completed payload; held until the next payload completes.

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - state=IDLE.
  - data_o=0, valid_o=0, done_o=0, ready_o=0, busy_o=0.
  - crc_o=0, internal crc=INIT, counters=0.
  - A reset mid-frame discards the frame; nothing further is emitted.
- States: IDLE, PAYLOAD, APPEND, DONE.
- IDLE:
  - ready_o=0, valid_o=0.
  - start_i=1: next state PAYLOAD, crc<=INIT, bit counter<=0.
- PAYLOAD:
  - ready_o=1, combinationally decoded from state.
  - Accept when valid_i & ready_o:
    - fb = crc[CS_WIDTH-1] ^ data_i.
    - crc <= (crc<<1) ^ (fb ? POLY : 0); MSB-first, no reflection, no final XOR.
    - data_o <= data_i, valid_o <= 1. Latency is 1 cycle input to output.
    - counter++.
  - valid_i=0: valid_o<=0; crc and counter hold. Gaps of any length are allowed.
  - Accept with counter==FRAME_LEN-1: next state APPEND, crc_o <= updated crc, shift counter<=0.
- APPEND:
  - ready_o=0; upstream must hold data.
  - Each cycle: data_o <= crc[CS_WIDTH-1], valid_o <= 1, crc <= crc<<1, counter++.
  - After CS_WIDTH loads, next state DONE.
  - Output is contiguous: exactly CS_WIDTH consecutive valid cycles with no gaps.
- DONE:
  - Lasts one cycle. data_o shows the last checksum bit, valid_o=1, done_o=1.
  - Next state IDLE; valid_o<=0.
- Boundary and simultaneous-event rules:
  - start_i outside IDLE is ignored; it neither restarts nor corrupts the frame.
  - start_i together with valid_i in IDLE: the data bit is not accepted, because ready_o=0 in IDLE.
  - FRAME_LEN=1: PAYLOAD lasts exactly one accepted bit.
  - Back-to-back frames: start_i may be asserted on the cycle after DONE.
  - Counters are sized $clog2(max(FRAME_LEN,CS_WIDTH))+1 and never wrap within a frame.
- Width rules: crc_o and the internal crc are exactly CS_WIDTH bits; POLY and INIT are truncated or extended to CS_WIDTH.

Test Plan:
- Reference vector:
  - Stimulus: defaults; start, then stream ASCII "123456789" (0x31..0x39), each byte MSB-first, valid_i continuous.
  - Response: data_o reproduces the 72 bits with 1-cycle delay, followed by 16 bits 0010100110110001 (0x29B1); crc_o=0x29B1; done_o high exactly with the last bit; busy_o low the next cycle.
- Throttled input:
  - Stimulus: same payload with valid_i toggling 1,0,0,1...
  - Response: identical output bit sequence and crc_o=0x29B1; valid_o mirrors accepted bits delayed 1 cycle; no checksum bit appears before the 72nd payload bit.
- Backpressure during append:
  - Stimulus: hold valid_i=1 with data through APPEND.
  - Response: ready_o=0 for 16 APPEND cycles plus DONE; no extra bits are consumed; the next frame after a new start_i starts from INIT again.
- Spurious start:
  - Stimulus: pulse start_i at payload bit 40 and again during APPEND.
  - Response: output identical to the reference vector, crc_o=0x29B1.
- Reset mid-frame:
  - Stimulus: drop rst_ni asynchronously at payload bit 20, release, then run the reference vector.
  - Response: all outputs 0 immediately; the subsequent frame yields 0x29B1.
- Back-to-back frames:
  - Stimulus: two reference frames with start_i the cycle after done_o.
  - Response: two identical 88-bit outputs; crc_o=0x29B1 after each.
